// File: rtl/alu_seq_ctrl_if.sv
// alu_seq_ctrl_if: request/response channels between calculator control and the ALU sequencer
interface alu_seq_ctrl_if #(parameter int NBYTES = 4);
  logic req_valid;
  logic req_ready;
  logic [2:0] req_opt;
  logic [8*NBYTES-1:0] req_a;
  logic [8*NBYTES-1:0] req_b;
  logic req_ci;
  logic rsp_valid;
  logic rsp_ready;
  logic [8*NBYTES-1:0] rsp_s;
  logic rsp_zero;
  logic rsp_co;
  logic rsp_err;
  modport master (
    output req_valid, req_opt, req_a, req_b, req_ci, rsp_ready,
    input  req_ready, rsp_valid, rsp_s, rsp_zero, rsp_co, rsp_err
  );
  modport slave (
    input  req_valid, req_opt, req_a, req_b, req_ci, rsp_ready,
    output req_ready, rsp_valid, rsp_s, rsp_zero, rsp_co, rsp_err
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: runs one N-byte operation through the shared 8-bit ALU, LSB first, chaining carry/borrow
module alu_seq_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic clk,
  input  logic rst_n,
  alu_seq_ctrl_if.slave bus,
  output logic [2:0] alu_opt,
  output logic [7:0] alu_numa,
  output logic [7:0] alu_numb,
  output logic alu_ci,
  input  logic [7:0] alu_s,
  input  logic alu_zero,
  input  logic alu_co
);
  localparam int W = 8*NBYTES;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [2:0] opt, idx;
  logic [W-1:0] a, b, acc, acc_nxt, s_r;
  logic ci, co, zacc, zero_r, co_r, err_r;
  logic legal, last, run, accept;
  always_comb begin
    legal = bus.req_opt != 3'd0 && bus.req_opt < 3'd6;
    run = state == RUN;
    last = idx == 3'(NBYTES-1);
    accept = state == IDLE && bus.req_valid;
    state_nxt = accept ? (legal ? RUN : DONE) :
                (run && last) ? DONE :
                (state == DONE && bus.rsp_ready) ? IDLE : state;
    alu_opt = run ? opt : 3'd0;
    alu_numa = run ? 8'(a >> {idx, 3'b000}) : 8'd0;
    alu_numb = run ? 8'(b >> {idx, 3'b000}) : 8'd0;
    alu_ci = run && (idx == 3'd0 ? ci : co);
    acc_nxt = (acc & ~(W'(8'hff) << {idx, 3'b000})) | (W'(alu_s) << {idx, 3'b000});
  end
  assign bus.req_ready = state == IDLE;
  assign bus.rsp_valid = state == DONE;
  assign bus.rsp_s = s_r;
  assign bus.rsp_zero = zero_r;
  assign bus.rsp_co = co_r;
  assign bus.rsp_err = err_r;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  // Response registers load only on entry to DONE so they hold through IDLE and RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opt <= '0;
      idx <= '0;
      a <= '0;
      b <= '0;
      ci <= 1'b0;
      co <= 1'b0;
      zacc <= 1'b0;
      acc <= '0;
      s_r <= '0;
      zero_r <= 1'b0;
      co_r <= 1'b0;
      err_r <= 1'b0;
    end else if (accept) begin
      opt <= bus.req_opt;
      a <= bus.req_a;
      b <= bus.req_b;
      ci <= bus.req_ci;
      idx <= '0;
      co <= 1'b0;
      zacc <= 1'b1;
      if (!legal) begin
        s_r <= '0;
        zero_r <= 1'b1;
        co_r <= 1'b0;
        err_r <= 1'b1;
      end
    end else if (run) begin
      acc <= acc_nxt;
      co <= alu_co;
      zacc <= zacc & alu_zero;
      idx <= last ? 3'd0 : idx + 3'd1;
      if (last) begin
        s_r <= opt == 3'd5 ? '0 : acc_nxt;
        zero_r <= zacc & alu_zero;
        co_r <= alu_co;
        err_r <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed scoreboard bench for alu_seq_ctrl with a behavioural 8-bit ALU
module tb_alu_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [2:0] alu_opt;
  logic [7:0] alu_numa, alu_numb, alu_s;
  logic alu_ci, alu_zero, alu_co;
  typedef struct {
    logic [31:0] s;
    logic z;
    logic co;
    logic err;
  } exp_t;
  exp_t q[$];
  int cmp_n = 0;
  int bad_n = 0;
  logic [7:0] ci_seq;
  alu_seq_ctrl_if #(.NBYTES(4)) bus();
  alu_seq_ctrl #(.NBYTES(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .alu_opt(alu_opt), .alu_numa(alu_numa), .alu_numb(alu_numb), .alu_ci(alu_ci),
    .alu_s(alu_s), .alu_zero(alu_zero), .alu_co(alu_co)
  );
  always #5 clk = ~clk;
  always_comb begin
    alu_s = 8'd0;
    alu_co = 1'b0;
    case (alu_opt)
      3'd1: {alu_co, alu_s} = 9'(alu_numa) + 9'(alu_numb) + 9'(alu_ci);
      3'd2, 3'd5: begin
        alu_s = alu_numa - alu_numb - 8'(alu_ci);
        alu_co = 9'(alu_numa) < 9'(alu_numb) + 9'(alu_ci);
      end
      3'd3: alu_s = alu_numa & alu_numb;
      3'd4: alu_s = alu_numa | alu_numb;
      default: ;
    endcase
    alu_zero = alu_s == 8'd0;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp_n++;
    assert (got === exp) else begin
      bad_n++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic ci,
                      input logic [31:0] es, input logic ez, input logic eco, input logic eer);
    exp_t e;
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_opt = o;
    bus.req_a = a;
    bus.req_b = b;
    bus.req_ci = ci;
    e.s = es;
    e.z = ez;
    e.co = eco;
    e.err = eer;
    q.push_back(e);
    while (n < 20) begin
      @(negedge clk);
      if (bus.req_ready) break;
      n++;
    end
    chk("accept", 32'(n < 20), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_opt = 3'd7;
    bus.req_a = $urandom;
    bus.req_b = $urandom;
    bus.req_ci = ~ci;
  endtask
  task automatic recv(input string tag, input int lat);
    exp_t e;
    int n = 0;
    logic rr = 1'b0;
    logic [2:0] done_opt = 3'd0;
    ci_seq = 8'd0;
    while (n <= 20) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        done_opt = alu_opt;
        break;
      end
      ci_seq[n[2:0]] = alu_ci;
      rr |= bus.req_ready;
      @(posedge clk);
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'(lat));
    chk({tag, " req_ready busy"}, 32'(rr), 32'd0);
    chk({tag, " alu_opt in done"}, 32'(done_opt), 32'd0);
    if (q.size() == 0) begin
      chk({tag, " scoreboard empty"}, 32'(q.size()), 32'd1);
    end else begin
      e = q.pop_front();
      chk({tag, " rsp_s"}, bus.rsp_s, e.s);
      chk({tag, " rsp_zero"}, 32'(bus.rsp_zero), 32'(e.z));
      chk({tag, " rsp_co"}, 32'(bus.rsp_co), 32'(e.co));
      chk({tag, " rsp_err"}, 32'(bus.rsp_err), 32'(e.err));
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    exp_t e;
    bus.req_valid = 1'b0;
    bus.req_opt = 3'd0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_ci = 1'b0;
    bus.rsp_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("reset req_ready", 32'(bus.req_ready), 32'd1);
    chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset rsp_s", bus.rsp_s, 32'd0);
    chk("reset rsp_zero", 32'(bus.rsp_zero), 32'd0);
    chk("reset alu_opt", 32'(alu_opt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(3'd1, 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0);
    recv("add_carry", 4);
    chk("add_carry alu_ci seq", 32'(ci_seq[3:0]), 32'hE);
    send(3'd1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    recv("add_wrap", 4);
    send(3'd2, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
    recv("sub_neg", 4);
    send(3'd2, 32'h0000_0100, 32'h0000_00FF, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    recv("sub_bin", 4);
    send(3'd5, 32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    recv("cmp_eq", 4);
    send(3'd5, 32'h0000_0010, 32'h0000_0020, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    recv("cmp_lt", 4);
    send(3'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 32'hF000_F000, 1'b0, 1'b0, 1'b0);
    recv("and", 4);
    send(3'd4, 32'h0F0F_0000, 32'h00F0_0001, 1'b1, 32'h0FFF_0001, 1'b0, 1'b0, 1'b0);
    recv("orr", 4);
    send(3'd7, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    recv("illegal7", 0);
    send(3'd0, 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    recv("illegal0", 0);
    bus.rsp_ready = 1'b0;
    send(3'd1, 32'h0000_0002, 32'h0000_0003, 1'b0, 32'h0000_0005, 1'b0, 1'b0, 1'b0);
    recv("bp_first", 4);
    bus.req_valid = 1'b1;
    bus.req_opt = 3'd1;
    bus.req_a = 32'h1111_1111;
    bus.req_b = 32'h2222_2222;
    bus.req_ci = 1'b0;
    e.s = 32'h3333_3333;
    e.z = 1'b0;
    e.co = 1'b0;
    e.err = 1'b0;
    q.push_back(e);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp req_ready", 32'(bus.req_ready), 32'd0);
      chk("bp rsp_s", bus.rsp_s, 32'h0000_0005);
      @(posedge clk);
    end
    #1 bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp idle req_ready", 32'(bus.req_ready), 32'd1);
    chk("bp idle rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("bp idle rsp_s held", bus.rsp_s, 32'h0000_0005);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_a = 32'hFFFF_FFFF;
    recv("bp_pending", 4);
    send(3'd1, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("midrun alu_opt", 32'(alu_opt), 32'd1);
    chk("midrun alu_numa", 32'(alu_numa), 32'h34);
    rst_n = 1'b0;
    #1;
    chk("async req_ready", 32'(bus.req_ready), 32'd1);
    chk("async rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("async rsp_s", bus.rsp_s, 32'd0);
    chk("async alu_opt", 32'(alu_opt), 32'd0);
    chk("async alu_numa", 32'(alu_numa), 32'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(3'd1, 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
    recv("post_reset", 4);
    chk("scoreboard drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
    $finish;
  end
endmodule
